// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: shares one dcache port between the load and store-commit pipes.
// Round-robin grant with store-urgency override, one outstanding transaction,
// timeout abort, and flush-killed load responses dropped.
// Ports: clock/resetn; i_flush, i_st_urgent; LD request (valid/ready/addr) and
// response (valid/data/err); ST request (valid/ready/addr/wdata/wmask) and
// response (valid/err); dcache request (valid/ready/addr/wen/wdata/wmask) and
// response (valid/data).
module dcache_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                i_flush,
  input  logic                i_st_urgent,
  input  logic                i_ld_valid,
  output logic                o_ld_ready,
  input  logic [ADDR_W-1:0]   i_ld_addr,
  output logic                o_ld_resp_valid,
  output logic [DATA_W-1:0]   o_ld_resp_data,
  output logic                o_ld_resp_err,
  input  logic                i_st_valid,
  output logic                o_st_ready,
  input  logic [ADDR_W-1:0]   i_st_addr,
  input  logic [DATA_W-1:0]   i_st_wdata,
  input  logic [DATA_W/8-1:0] i_st_wmask,
  output logic                o_st_resp_valid,
  output logic                o_st_resp_err,
  output logic                o_dc_req_valid,
  input  logic                i_dc_req_ready,
  output logic [ADDR_W-1:0]   o_dc_req_addr,
  output logic                o_dc_req_wen,
  output logic [DATA_W-1:0]   o_dc_req_wdata,
  output logic [DATA_W/8-1:0] o_dc_req_wmask,
  input  logic                i_dc_resp_valid,
  input  logic [DATA_W-1:0]   i_dc_resp_data
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  localparam logic [7:0] TMO = 8'(TIMEOUT);
  state_t state_q, state_d;
  // The last granted requester is also the current owner (1 = ST).
  logic rr_q, rr_d;
  logic killed_q, killed_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wmask_q, wmask_d;
  logic ld_rvalid_q, ld_rvalid_d, ld_rerr_q, ld_rerr_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;
  logic st_rvalid_q, st_rvalid_d, st_rerr_q, st_rerr_d;
  logic idle, issue, ld_ok, st_gnt, ld_gnt, gnt, done;
  assign idle   = state_q == IDLE;
  assign issue  = state_q == ISSUE;
  assign ld_ok  = i_ld_valid & ~i_flush;
  assign st_gnt = idle & i_st_valid & (i_st_urgent | ~ld_ok | ~rr_q);
  assign ld_gnt = idle & ld_ok & ~st_gnt;
  assign gnt    = ld_gnt | st_gnt;
  // A response arriving in the timeout cycle wins over the abort.
  assign done   = (state_q == WAIT) & (i_dc_resp_valid | (tcnt_q == TMO));
  assign o_ld_ready      = ld_gnt & resetn;
  assign o_st_ready      = st_gnt & resetn;
  assign o_dc_req_valid  = issue;
  assign o_dc_req_addr   = issue ? addr_q : '0;
  assign o_dc_req_wen    = issue & rr_q;
  assign o_dc_req_wdata  = issue ? wdata_q : '0;
  assign o_dc_req_wmask  = issue ? wmask_q : '0;
  assign o_ld_resp_valid = ld_rvalid_q;
  assign o_ld_resp_data  = ld_rdata_q;
  assign o_ld_resp_err   = ld_rerr_q;
  assign o_st_resp_valid = st_rvalid_q;
  assign o_st_resp_err   = st_rerr_q;
  always_comb begin
    state_d     = gnt ? ISSUE : (issue & i_dc_req_ready) ? WAIT : done ? IDLE : state_q;
    rr_d        = gnt ? st_gnt : rr_q;
    addr_d      = gnt ? (st_gnt ? i_st_addr : i_ld_addr) : addr_q;
    wdata_d     = gnt ? (st_gnt ? i_st_wdata : '0) : wdata_q;
    wmask_d     = gnt ? (st_gnt ? i_st_wmask : '0) : wmask_q;
    tcnt_d      = (state_q == WAIT) ? tcnt_q + 8'd1 : '0;
    // A flush in the completing cycle still kills the load.
    killed_d    = done ? 1'b0 : killed_q | (~idle & ~rr_q & i_flush);
    ld_rvalid_d = done & ~rr_q & ~killed_q & ~i_flush;
    ld_rerr_d   = ld_rvalid_d & ~i_dc_resp_valid;
    ld_rdata_d  = (ld_rvalid_d & i_dc_resp_valid) ? i_dc_resp_data : ld_rdata_q;
    st_rvalid_d = done & rr_q;
    st_rerr_d   = st_rvalid_d & ~i_dc_resp_valid;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      rr_q        <= 1'b1;
      killed_q    <= 1'b0;
      tcnt_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      ld_rvalid_q <= 1'b0;
      ld_rerr_q   <= 1'b0;
      ld_rdata_q  <= '0;
      st_rvalid_q <= 1'b0;
      st_rerr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      killed_q    <= killed_d;
      tcnt_q      <= tcnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      ld_rvalid_q <= ld_rvalid_d;
      ld_rerr_q   <= ld_rerr_d;
      ld_rdata_q  <= ld_rdata_d;
      st_rvalid_q <= st_rvalid_d;
      st_rerr_q   <= st_rerr_d;
    end
  end
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb_dcache_port_arbiter: directed self-checking bench for dcache_port_arbiter.
module tb_dcache_port_arbiter;
  logic clock = 1'b0;
  logic resetn, i_flush, i_st_urgent;
  logic i_ld_valid, o_ld_ready, o_ld_resp_valid, o_ld_resp_err;
  logic [31:0] i_ld_addr, i_st_addr, o_dc_req_addr;
  logic [63:0] o_ld_resp_data, i_st_wdata, o_dc_req_wdata, i_dc_resp_data;
  logic i_st_valid, o_st_ready, o_st_resp_valid, o_st_resp_err;
  logic [7:0] i_st_wmask, o_dc_req_wmask;
  logic o_dc_req_valid, i_dc_req_ready, o_dc_req_wen, i_dc_resp_valid;
  int n_chk = 0;
  int n_fail = 0;
  dcache_port_arbiter #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(4)) dut (
    .clock(clock), .resetn(resetn), .i_flush(i_flush), .i_st_urgent(i_st_urgent),
    .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready), .i_ld_addr(i_ld_addr),
    .o_ld_resp_valid(o_ld_resp_valid), .o_ld_resp_data(o_ld_resp_data), .o_ld_resp_err(o_ld_resp_err),
    .i_st_valid(i_st_valid), .o_st_ready(o_st_ready), .i_st_addr(i_st_addr),
    .i_st_wdata(i_st_wdata), .i_st_wmask(i_st_wmask),
    .o_st_resp_valid(o_st_resp_valid), .o_st_resp_err(o_st_resp_err),
    .o_dc_req_valid(o_dc_req_valid), .i_dc_req_ready(i_dc_req_ready), .o_dc_req_addr(o_dc_req_addr),
    .o_dc_req_wen(o_dc_req_wen), .o_dc_req_wdata(o_dc_req_wdata), .o_dc_req_wmask(o_dc_req_wmask),
    .i_dc_resp_valid(i_dc_resp_valid), .i_dc_resp_data(i_dc_resp_data)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #2;
  endtask
  task automatic finish_txn(input logic [63:0] d);
    i_dc_req_ready = 1'b1;
    tick();
    i_dc_req_ready = 1'b0;
    i_dc_resp_valid = 1'b1;
    i_dc_resp_data = d;
    tick();
    i_dc_resp_valid = 1'b0;
  endtask
  initial begin
    resetn = 1'b0; i_flush = 1'b0; i_st_urgent = 1'b0;
    i_ld_valid = 1'b1; i_ld_addr = 32'h1000;
    i_st_valid = 1'b1; i_st_addr = 32'h2000; i_st_wdata = 64'h1122334455667788; i_st_wmask = 8'h0F;
    i_dc_req_ready = 1'b0; i_dc_resp_valid = 1'b0; i_dc_resp_data = '0;
    #3;
    chk("rst_ld_ready", o_ld_ready, 0);
    chk("rst_st_ready", o_st_ready, 0);
    chk("rst_dc_valid", o_dc_req_valid, 0);
    chk("rst_ld_resp", o_ld_resp_valid, 0);
    chk("rst_st_resp", o_st_resp_valid, 0);
    tick(); tick();
    resetn = 1'b1;
    // T1/T2: tie after reset -> LD first
    #1;
    chk("t1_ld_ready", o_ld_ready, 1);
    chk("t1_st_ready", o_st_ready, 0);
    tick();
    i_ld_valid = 1'b0;
    #1;
    chk("t1_issue_valid", o_dc_req_valid, 1);
    chk("t1_issue_addr", o_dc_req_addr, 32'h1000);
    chk("t1_issue_wen", o_dc_req_wen, 0);
    chk("t1_no_st_ready", o_st_ready, 0);
    i_dc_req_ready = 1'b1;
    tick();
    i_dc_req_ready = 1'b0;
    chk("t1_wait_noreq", o_dc_req_valid, 0);
    tick();
    i_dc_resp_valid = 1'b1;
    i_dc_resp_data = 64'hDEADBEEF_00C0FFEE;
    chk("t2_no_early_resp", o_ld_resp_valid, 0);
    tick();
    i_dc_resp_valid = 1'b0;
    chk("t2_ld_resp_valid", o_ld_resp_valid, 1);
    chk("t2_ld_resp_data", o_ld_resp_data, 64'hDEADBEEF_00C0FFEE);
    chk("t2_ld_resp_err", o_ld_resp_err, 0);
    #1;
    chk("t1_b2b_st_ready", o_st_ready, 1);
    tick();
    i_st_valid = 1'b0;
    chk("t2_pulse_1cyc", o_ld_resp_valid, 0);
    chk("t1_st_wen", o_dc_req_wen, 1);
    chk("t1_st_addr", o_dc_req_addr, 32'h2000);
    chk("t1_st_wdata", o_dc_req_wdata, 64'h1122334455667788);
    chk("t1_st_wmask", o_dc_req_wmask, 8'h0F);
    finish_txn(64'h0);
    chk("t1_st_ack", o_st_resp_valid, 1);
    chk("t1_st_ack_err", o_st_resp_err, 0);
    chk("t1_st_no_ld", o_ld_resp_valid, 0);
    // rr alternation over repeated ties
    i_ld_valid = 1'b1; i_st_valid = 1'b1; i_ld_addr = 32'h1100;
    #1;
    chk("rr_tie2_ld", o_ld_ready, 1);
    chk("rr_tie2_st", o_st_ready, 0);
    tick();
    i_ld_valid = 1'b0;
    finish_txn(64'h1);
    chk("rr_ld_data", o_ld_resp_data, 64'h1);
    i_ld_valid = 1'b1;
    #1;
    chk("rr_tie3_st", o_st_ready, 1);
    chk("rr_tie3_ld", o_ld_ready, 0);
    tick();
    i_st_valid = 1'b0;
    finish_txn(64'h0);
    chk("rr_st_ack", o_st_resp_valid, 1);
    // T3: urgent store overrides rr that favours LD
    i_st_valid = 1'b1; i_st_urgent = 1'b1; i_st_addr = 32'h2040;
    i_st_wdata = 64'hA5A5A5A5_5A5A5A5A; i_st_wmask = 8'hFF;
    #1;
    chk("t3_st_ready", o_st_ready, 1);
    chk("t3_ld_ready", o_ld_ready, 0);
    tick();
    i_st_valid = 1'b0; i_st_urgent = 1'b0; i_ld_valid = 1'b0;
    chk("t3_wen", o_dc_req_wen, 1);
    chk("t3_wmask", o_dc_req_wmask, 8'hFF);
    chk("t3_wdata", o_dc_req_wdata, 64'hA5A5A5A5_5A5A5A5A);
    // T6a: dcache not ready for 5 cycles -> request held stable
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_hold_valid", o_dc_req_valid, 1);
      chk("t6_hold_addr", o_dc_req_addr, 32'h2040);
    end
    finish_txn(64'h0);
    chk("t6_hold_ack", o_st_resp_valid, 1);
    // T4: flush in IDLE blocks LD grant; flush in WAIT drops response
    i_ld_valid = 1'b1; i_ld_addr = 32'h3000; i_flush = 1'b1;
    #1;
    chk("t4_flush_idle", o_ld_ready, 0);
    tick();
    i_flush = 1'b0;
    #1;
    chk("t4_ld_ready", o_ld_ready, 1);
    tick();
    i_ld_valid = 1'b0;
    i_dc_req_ready = 1'b1;
    tick();
    i_dc_req_ready = 1'b0;
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    i_dc_resp_valid = 1'b1; i_dc_resp_data = 64'h77;
    tick();
    i_dc_resp_valid = 1'b0;
    chk("t4_dropped", o_ld_resp_valid, 0);
    i_st_valid = 1'b1; i_st_addr = 32'h4000;
    #1;
    chk("t4_next_grant", o_st_ready, 1);
    // T5: timeout, never answered
    tick();
    i_st_valid = 1'b0;
    i_dc_req_ready = 1'b1;
    tick();
    i_dc_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_resp_yet", o_st_resp_valid, 0);
    end
    tick();
    chk("t5_to_valid", o_st_resp_valid, 1);
    chk("t5_to_err", o_st_resp_err, 1);
    i_dc_resp_valid = 1'b1;
    tick();
    i_dc_resp_valid = 1'b0;
    chk("t5_late_st", o_st_resp_valid, 0);
    chk("t5_late_ld", o_ld_resp_valid, 0);
    chk("t5_late_idle", o_dc_req_valid, 0);
    // T6b: reset mid-WAIT
    i_ld_valid = 1'b1; i_ld_addr = 32'h5000;
    #1;
    chk("t6_ld_ready", o_ld_ready, 1);
    tick();
    i_ld_valid = 1'b0;
    i_dc_req_ready = 1'b1;
    tick();
    i_dc_req_ready = 1'b0;
    resetn = 1'b0;
    i_dc_resp_valid = 1'b1;
    #1;
    chk("t6_rst_valid", o_dc_req_valid, 0);
    chk("t6_rst_addr", o_dc_req_addr, 0);
    chk("t6_rst_ld_resp", o_ld_resp_valid, 0);
    chk("t6_rst_st_resp", o_st_resp_valid, 0);
    tick();
    resetn = 1'b1;
    i_dc_resp_valid = 1'b0;
    tick();
    chk("t6_resp_lost", o_ld_resp_valid, 0);
    chk("t6_idle_after", o_dc_req_valid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
